// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the I/D-cache main-memory arbiter.
// Holds the arbiter state encoding, requester identity and the tie-break helper.
package mem_arb_pkg;

    localparam int ADDR_BITS         = 16;
    localparam int DATA_BITS         = 16;
    localparam int BLOCK_OFFSET_BITS = 4;
    localparam int WORD_IDX_BITS     = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_FILL  = 2'd1,
        D_FILL  = 2'd2,
        D_WRITE = 2'd3
    } arbState_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_t;

    // On a tie the side that was not granted last wins.
    function automatic requester_t pickWinner(
        input logic       iReq,
        input logic       dReq,
        input requester_t lastGrant
    );
        if (iReq && dReq) begin
            return (lastGrant == REQ_I) ? REQ_D : REQ_I;
        end else if (dReq) begin
            return REQ_D;
        end else begin
            return REQ_I;
        end
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_block_fill_seq.sv
// Block-fill sequencer: issues the word addresses of one cache block and
// counts the returned words, flagging the last one.
module block_fill_seq
    import mem_arb_pkg::*;
#(
    parameter int WORDS = 8
)
(
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    active,
    input  logic [ADDR_BITS-1:BLOCK_OFFSET_BITS]    baseAddr,
    input  logic                                    memDataValid,
    output logic                                    issue,
    output logic [ADDR_BITS-1:0]                    fillAddr,
    output logic [WORD_IDX_BITS-1:0]                wordIdx,
    output logic                                    wordValid,
    output logic                                    lastWord
);

    localparam logic [WORD_IDX_BITS-1:0] LAST_IDX = WORD_IDX_BITS'(WORDS - 1);

    logic [WORD_IDX_BITS-1:0] issCnt;
    logic [WORD_IDX_BITS-1:0] retCnt;
    logic                     issuedAll;

    assign issue     = active && !issuedAll;
    assign fillAddr  = {baseAddr, issCnt, 1'b0};
    assign wordValid = active && memDataValid;
    assign wordIdx   = retCnt;
    assign lastWord  = wordValid && (retCnt == LAST_IDX);

    // issCnt parks on the last index; issuedAll stops further issue instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issCnt    <= '0;
            retCnt    <= '0;
            issuedAll <= 1'b0;
        end else if (!active || lastWord) begin
            issCnt    <= '0;
            retCnt    <= '0;
            issuedAll <= 1'b0;
        end else begin
            if (issue) begin
                if (issCnt == LAST_IDX) begin
                    issuedAll <= 1'b1;
                end else begin
                    issCnt <= issCnt + 1'b1;
                end
            end
            if (wordValid) begin
                retCnt <= retCnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single pipelined memory port between I-cache fills and
// D-cache fills/write-through stores, steering returned words to the owner.
module cache_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY     = 4,
    parameter int WORDS_PER_BLOCK = 8
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_req,
    input  logic [ADDR_BITS-1:0]     i_addr,
    input  logic                     d_req,
    input  logic                     d_wr,
    input  logic [ADDR_BITS-1:0]     d_addr,
    input  logic [DATA_BITS-1:0]     d_wdata,
    output logic                     i_grant,
    output logic                     d_grant,
    output logic                     i_data_valid,
    output logic                     d_data_valid,
    output logic [WORD_IDX_BITS-1:0] word_idx,
    output logic                     i_done,
    output logic                     d_done,
    output logic                     mem_enable,
    output logic                     mem_wr,
    output logic [ADDR_BITS-1:0]     mem_addr,
    output logic [DATA_BITS-1:0]     mem_wdata,
    input  logic                     mem_data_valid,
    input  logic [DATA_BITS-1:0]     mem_rdata
);

    // The memory latency is a property of the attached memory; only its legality matters here.
    generate
        if (MEM_LATENCY < 1) begin : gBadLatency
            $error("cache_mem_arbiter: MEM_LATENCY must be at least 1");
        end
        if (WORDS_PER_BLOCK != (1 << WORD_IDX_BITS)) begin : gBadBlock
            $error("cache_mem_arbiter: WORDS_PER_BLOCK must match WORD_IDX_BITS");
        end
    endgenerate

    arbState_t                state;
    requester_t               lastGrant;
    requester_t               winner;
    logic [ADDR_BITS-1:1]     addrLatch;
    logic [DATA_BITS-1:0]     wdataLatch;

    logic                     fillActive;
    logic                     seqIssue;
    logic [ADDR_BITS-1:0]     seqAddr;
    logic [WORD_IDX_BITS-1:0] seqWordIdx;
    logic                     seqWordValid;
    logic                     seqLastWord;

    // Byte-lane bit 0 never reaches memory: every access is word aligned.
    logic                     unusedAddrBits;
    assign unusedAddrBits = ^{i_addr[0], d_addr[0], mem_rdata};

    assign fillActive = (state == I_FILL) || (state == D_FILL);
    assign winner     = pickWinner(i_req, d_req, lastGrant);

    block_fill_seq #(
        .WORDS        (WORDS_PER_BLOCK)
    ) uFillSeq (
        .clk          (clk),
        .rst_n        (rst_n),
        .active       (fillActive),
        .baseAddr     (addrLatch[ADDR_BITS-1:BLOCK_OFFSET_BITS]),
        .memDataValid (mem_data_valid),
        .issue        (seqIssue),
        .fillAddr     (seqAddr),
        .wordIdx      (seqWordIdx),
        .wordValid    (seqWordValid),
        .lastWord     (seqLastWord)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lastGrant  <= REQ_I;
            addrLatch  <= '0;
            wdataLatch <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        lastGrant  <= winner;
                        wdataLatch <= d_wdata;
                        if (winner == REQ_D) begin
                            state     <= d_wr ? D_WRITE : D_FILL;
                            addrLatch <= d_addr[ADDR_BITS-1:1];
                        end else begin
                            state     <= I_FILL;
                            addrLatch <= i_addr[ADDR_BITS-1:1];
                        end
                    end
                end
                I_FILL, D_FILL: begin
                    if (seqLastWord) begin
                        state <= IDLE;
                    end
                end
                D_WRITE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign i_grant      = (state == I_FILL);
    assign d_grant      = (state == D_FILL) || (state == D_WRITE);
    assign i_data_valid = seqWordValid && (state == I_FILL);
    assign d_data_valid = seqWordValid && (state == D_FILL);
    assign word_idx     = fillActive ? seqWordIdx : '0;
    assign i_done       = seqLastWord && (state == I_FILL);
    assign d_done       = (seqLastWord && (state == D_FILL)) || (state == D_WRITE);

    assign mem_enable   = seqIssue || (state == D_WRITE);
    assign mem_wr       = (state == D_WRITE);
    assign mem_addr     = (state == D_WRITE) ? {addrLatch, 1'b0}
                        : (seqIssue ? seqAddr : '0);
    assign mem_wdata    = wdataLatch;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: fills, writes, ties, request drop,
// asynchronous reset mid-fill and a minimum-latency instance.
module tb_cache_mem_arbiter;

    localparam int LAT_A = 4;
    localparam int LAT_B = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_grant, d_grant, i_data_valid, d_data_valid, i_done, d_done;
    logic        mem_enable, mem_wr, mem_data_valid;
    logic [2:0]  word_idx;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    logic        i_reqB, d_reqB, d_wrB;
    logic [15:0] i_addrB, d_addrB, d_wdataB;
    logic        i_grantB, d_grantB, i_data_validB, d_data_validB, i_doneB, d_doneB;
    logic        mem_enableB, mem_wrB, mem_data_validB;
    logic [2:0]  word_idxB;
    logic [15:0] mem_addrB, mem_wdataB, mem_rdataB;

    int vectors = 0;
    int miscompares = 0;

    cache_mem_arbiter #(.MEM_LATENCY(LAT_A), .WORDS_PER_BLOCK(8)) dutA (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .i_grant(i_grant), .d_grant(d_grant),
        .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
        .word_idx(word_idx), .i_done(i_done), .d_done(d_done),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_data_valid(mem_data_valid), .mem_rdata(mem_rdata)
    );

    cache_mem_arbiter #(.MEM_LATENCY(LAT_B), .WORDS_PER_BLOCK(8)) dutB (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_reqB), .i_addr(i_addrB),
        .d_req(d_reqB), .d_wr(d_wrB), .d_addr(d_addrB), .d_wdata(d_wdataB),
        .i_grant(i_grantB), .d_grant(d_grantB),
        .i_data_valid(i_data_validB), .d_data_valid(d_data_validB),
        .word_idx(word_idxB), .i_done(i_doneB), .d_done(d_doneB),
        .mem_enable(mem_enableB), .mem_wr(mem_wrB), .mem_addr(mem_addrB),
        .mem_wdata(mem_wdataB), .mem_data_valid(mem_data_validB), .mem_rdata(mem_rdataB)
    );

    // Pipelined memories: a read issued in cycle c returns in cycle c+LAT, data = addr ^ A5A5.
    logic        vldPipeA  [LAT_A] = '{default: 1'b0};
    logic [15:0] addrPipeA [LAT_A] = '{default: 16'h0};
    logic        vldPipeB  [LAT_B] = '{default: 1'b0};
    logic [15:0] addrPipeB [LAT_B] = '{default: 16'h0};

    always @(posedge clk) begin
        vldPipeA[0]  <= mem_enable && !mem_wr;
        addrPipeA[0] <= mem_addr;
        for (int k = 1; k < LAT_A; k++) begin
            vldPipeA[k]  <= vldPipeA[k-1];
            addrPipeA[k] <= addrPipeA[k-1];
        end
        vldPipeB[0]  <= mem_enableB && !mem_wrB;
        addrPipeB[0] <= mem_addrB;
        for (int k = 1; k < LAT_B; k++) begin
            vldPipeB[k]  <= vldPipeB[k-1];
            addrPipeB[k] <= addrPipeB[k-1];
        end
    end

    assign mem_data_valid  = vldPipeA[LAT_A-1];
    assign mem_rdata       = addrPipeA[LAT_A-1] ^ 16'hA5A5;
    assign mem_data_validB = vldPipeB[LAT_B-1];
    assign mem_rdataB      = addrPipeB[LAT_B-1] ^ 16'hA5A5;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [39:0] outs;
        rst_n = 1'b0;
        i_req = 0; d_req = 0; d_wr = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
        i_reqB = 0; d_reqB = 0; d_wrB = 0; i_addrB = 0; d_addrB = 0; d_wdataB = 0;
        #3;
        outs = {i_grant, d_grant, i_data_valid, d_data_valid, word_idx, i_done, d_done,
                mem_enable, mem_wr, mem_addr, mem_wdata};
        vectors++;
        if (outs !== 40'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h want=0", outs);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        outs = {i_grant, d_grant, i_data_valid, d_data_valid, word_idx, i_done, d_done,
                mem_enable, mem_wr, mem_addr, mem_wdata};
        vectors++;
        if (outs !== 40'h0) begin
            miscompares++;
            $display("FAIL idle_after_reset got=%h want=0", outs);
        end
        vectors++;
        if ({i_grantB, d_grantB, mem_enableB} !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_after_reset_B got=%b want=000", {i_grantB, d_grantB, mem_enableB});
        end
    endtask

    task automatic test_tie();
        i_addr = 16'h2000; d_addr = 16'h3008; d_wr = 0;
        i_req = 1; d_req = 1;
        step();
        for (int c = 0; c <= 7 + LAT_A; c++) begin
            vectors++;
            if ({d_grant, i_grant} !== 2'b10) begin
                miscompares++;
                $display("FAIL tie1_grant c=%0d got d/i=%b want=10", c, {d_grant, i_grant});
            end
            if (c == 0) begin
                vectors++;
                if (mem_addr !== 16'h3000) begin
                    miscompares++;
                    $display("FAIL tie1_first_addr got=%h want=3000", mem_addr);
                end
            end
            if (c == 7 + LAT_A) begin
                vectors++;
                if (d_done !== 1'b1) begin
                    miscompares++;
                    $display("FAIL tie1_d_done got=%b want=1", d_done);
                end
                d_req = 0;
            end
            step();
        end
        vectors++;
        if ({d_grant, i_grant} !== 2'b00) begin
            miscompares++;
            $display("FAIL tie_idle_gap got d/i=%b want=00", {d_grant, i_grant});
        end
        step();
        vectors++;
        if ({i_grant, mem_addr} !== {1'b1, 16'h2000}) begin
            miscompares++;
            $display("FAIL i_after_d got grant=%b addr=%h want grant=1 addr=2000", i_grant, mem_addr);
        end
        for (int c = 0; c <= 7 + LAT_A; c++) begin
            if (c == 2) d_req = 1;
            if (c == 7 + LAT_A) begin
                vectors++;
                if ({i_done, d_grant} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL tie2_i_done got done/dgrant=%b want=10", {i_done, d_grant});
                end
            end
            step();
        end
        step();
        vectors++;
        if ({d_grant, i_grant} !== 2'b10) begin
            miscompares++;
            $display("FAIL tie2_goes_to_d got d/i=%b want=10", {d_grant, i_grant});
        end
        i_req = 0; d_req = 0;
        for (int c = 1; c <= 7 + LAT_A; c++) step();
        vectors++;
        if (d_done !== 1'b1) begin
            miscompares++;
            $display("FAIL tie2_d_done got=%b want=1", d_done);
        end
        step();
    endtask

    task automatic test_i_fill(input int dropAt);
        logic expGrant, expEn, expVld;
        i_addr = 16'h1236; i_req = 1; d_req = 0;
        step();
        for (int c = 0; c <= 8 + LAT_A; c++) begin
            expGrant = (c <= 7 + LAT_A);
            expEn    = (c < 8);
            expVld   = (c >= LAT_A) && (c <= 7 + LAT_A);
            vectors++;
            if ({i_grant, d_grant} !== {expGrant, 1'b0}) begin
                miscompares++;
                $display("FAIL fill_grant drop=%0d c=%0d got i/d=%b want=%b0", dropAt, c, {i_grant, d_grant}, expGrant);
            end
            vectors++;
            if ({mem_enable, mem_wr} !== {expEn, 1'b0}) begin
                miscompares++;
                $display("FAIL fill_enable drop=%0d c=%0d got en/wr=%b want=%b0", dropAt, c, {mem_enable, mem_wr}, expEn);
            end
            if (expEn) begin
                vectors++;
                if (mem_addr !== 16'h1230 + 16'(2 * c)) begin
                    miscompares++;
                    $display("FAIL fill_addr drop=%0d c=%0d got=%h want=%h", dropAt, c, mem_addr, 16'h1230 + 16'(2 * c));
                end
            end
            vectors++;
            if ({i_data_valid, d_data_valid} !== {expVld, 1'b0}) begin
                miscompares++;
                $display("FAIL fill_valid drop=%0d c=%0d got i/d=%b want=%b0", dropAt, c, {i_data_valid, d_data_valid}, expVld);
            end
            if (expVld) begin
                vectors++;
                if ({word_idx, mem_rdata} !== {3'(c - LAT_A), (16'h1230 + 16'(2 * (c - LAT_A))) ^ 16'hA5A5}) begin
                    miscompares++;
                    $display("FAIL fill_word drop=%0d c=%0d got idx=%0d data=%h want idx=%0d", dropAt, c, word_idx, mem_rdata, c - LAT_A);
                end
            end
            vectors++;
            if (i_done !== (c == 7 + LAT_A)) begin
                miscompares++;
                $display("FAIL fill_done drop=%0d c=%0d got=%b want=%b", dropAt, c, i_done, (c == 7 + LAT_A));
            end
            if (c == dropAt || c == 7 + LAT_A) i_req = 0;
            step();
        end
    endtask

    task automatic test_d_write();
        d_req = 1; d_wr = 1; d_addr = 16'h4005; d_wdata = 16'hBEEF;
        step();
        vectors++;
        if ({d_grant, i_grant, mem_enable, mem_wr, d_done} !== 5'b10111) begin
            miscompares++;
            $display("FAIL write_strobes got dg/ig/en/wr/done=%b want=10111", {d_grant, i_grant, mem_enable, mem_wr, d_done});
        end
        vectors++;
        if ({mem_addr, mem_wdata} !== {16'h4004, 16'hBEEF}) begin
            miscompares++;
            $display("FAIL write_addr_data got addr=%h data=%h want 4004/BEEF", mem_addr, mem_wdata);
        end
        d_req = 0; d_wr = 0; d_addr = 16'hFFFF; d_wdata = 16'h0BAD;
        step();
        vectors++;
        if ({d_grant, mem_enable, d_done, mem_wdata} !== {3'b000, 16'hBEEF}) begin
            miscompares++;
            $display("FAIL write_release got dg/en/done=%b data=%h want 000/BEEF", {d_grant, mem_enable, d_done}, mem_wdata);
        end
    endtask

    task automatic test_reset_mid_fill();
        int seenValid = 0;
        i_addr = 16'h5550; i_req = 1;
        step();
        repeat (5) step();
        i_req = 0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({i_grant, d_grant, mem_enable, i_data_valid, i_done, word_idx, mem_addr, mem_wdata} !== 40'h0) begin
            miscompares++;
            $display("FAIL async_reset got g=%b en=%b v=%b idx=%0d addr=%h wd=%h want all 0",
                     {i_grant, d_grant}, mem_enable, i_data_valid, word_idx, mem_addr, mem_wdata);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (mem_data_valid) seenValid++;
            vectors++;
            if ({i_data_valid, d_data_valid, i_done, d_done, i_grant} !== 5'b0) begin
                miscompares++;
                $display("FAIL stale_return c=%0d got v/done/grant=%b want=0 (mem valid=%b)",
                         c, {i_data_valid, d_data_valid, i_done, d_done, i_grant}, mem_data_valid);
            end
            step();
        end
        vectors++;
        if (seenValid < 1) begin
            miscompares++;
            $display("FAIL stale_return_present got=%0d want>=1", seenValid);
        end
        d_req = 1; d_wr = 1; d_addr = 16'h6002; d_wdata = 16'h1234;
        step();
        vectors++;
        if ({d_grant, mem_wr, d_done, mem_addr, mem_wdata} !== {3'b111, 16'h6002, 16'h1234}) begin
            miscompares++;
            $display("FAIL write_after_reset got g/wr/done=%b addr=%h data=%h want 111/6002/1234",
                     {d_grant, mem_wr, d_done}, mem_addr, mem_wdata);
        end
        d_req = 0; d_wr = 0;
        step();
    endtask

    task automatic test_latency1();
        logic expVld;
        i_addrB = 16'h777A; i_reqB = 1;
        step();
        for (int c = 0; c <= 9; c++) begin
            expVld = (c >= LAT_B) && (c <= 7 + LAT_B);
            vectors++;
            if ({i_grantB, i_data_validB, i_doneB} !== {(c <= 8), expVld, (c == 8)}) begin
                miscompares++;
                $display("FAIL lat1_ctrl c=%0d got g/v/done=%b want=%b", c,
                         {i_grantB, i_data_validB, i_doneB}, {(c <= 8), expVld, (c == 8)});
            end
            if (expVld) begin
                vectors++;
                if ({word_idxB, mem_rdataB} !== {3'(c - 1), (16'h7770 + 16'(2 * (c - 1))) ^ 16'hA5A5}) begin
                    miscompares++;
                    $display("FAIL lat1_word c=%0d got idx=%0d data=%h want idx=%0d", c, word_idxB, mem_rdataB, c - 1);
                end
            end
            if (c == 8) i_reqB = 0;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_i_fill(100);
        test_d_write();
        test_i_fill(3);
        test_reset_mid_fill();
        test_latency1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before bench completion");
        $fatal(1, "watchdog");
    end

endmodule
